// File: rtl/pix_pkg.sv
// Shared pixel types and colour-map constants for the pseudocolour stage.
package pix_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    CMAP_GRAY   = 2'd0,
    CMAP_JET    = 2'd1,
    CMAP_HEAT   = 2'd2,
    CMAP_THRESH = 2'd3
  } cmap_e;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

endpackage

// File: rtl/colormap_lut.sv
// Combinational false-colour map from an 8-bit luminance sample to RGB.
module colormap_lut
  import pix_pkg::*;
(
  input  logic [7:0] i_y,
  input  cmap_e      i_mode,
  input  logic [7:0] i_thr,
  output rgb_t       o_rgb
);

  logic [7:0] w_d;
  logic [7:0] w_dbl;

  // Jet ramps use the position inside each 64-wide band, heat uses Y folded at 128.
  assign w_d   = {i_y[5:0], 2'b00};
  assign w_dbl = {i_y[6:0], 1'b0};

  always_comb begin
    o_rgb = BLACK;
    case (i_mode)
      CMAP_GRAY: o_rgb = {i_y, i_y, i_y};
      CMAP_JET: begin
        case (i_y[7:6])
          2'd0:    o_rgb = {8'h00, w_d,   8'hFF};
          2'd1:    o_rgb = {8'h00, 8'hFF, ~w_d};
          2'd2:    o_rgb = {w_d,   8'hFF, 8'h00};
          default: o_rgb = {8'hFF, ~w_d,  8'h00};
        endcase
      end
      CMAP_HEAT: begin
        if (i_y[7]) o_rgb = {8'hFF, w_dbl, 8'h00};
        else        o_rgb = {w_dbl, 8'h00, 8'h00};
      end
      CMAP_THRESH: o_rgb = (i_y >= i_thr) ? WHITE : BLACK;
      default:     o_rgb = BLACK;
    endcase
  end

endmodule

// File: rtl/gray_to_pseudocolor.sv
// Two-stage valid/ready pipeline expanding luminance to 24-bit RGB via colormap_lut.
module gray_to_pseudocolor
  import pix_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_y,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [7:0]       thr,
  output logic [23:0]      pix_out,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pix_count
);

  logic       w_adv1;
  logic       w_adv2;
  rgb_t       w_rgb;

  logic       r_s1_valid;
  logic [7:0] r_s1_y;
  logic       r_s1_last;
  cmap_e      r_s1_mode;
  logic [7:0] r_s1_thr;

  rgb_t             r_pix;
  logic             r_out_last;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_count;

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_adv2   = !r_out_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_y     <= '0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= CMAP_GRAY;
      r_s1_thr   <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      r_s1_y     <= in_y;
      r_s1_last  <= in_last;
      r_s1_mode  <= cmap_e'(mode);
      r_s1_thr   <= thr;
    end
  end

  colormap_lut u_lut (
    .i_y    (r_s1_y),
    .i_mode (r_s1_mode),
    .i_thr  (r_s1_thr),
    .o_rgb  (w_rgb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_pix       <= BLACK;
      r_out_last  <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      r_pix       <= w_rgb;
      r_out_last  <= r_s1_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_out_valid && out_ready) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign pix_out   = r_pix;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign pix_count = r_count;

endmodule

// File: doc/gray_to_pseudocolor.md
Name: gray_to_pseudocolor

Overview:
- Streaming colour-mapping stage: takes an 8-bit luminance pixel stream (Y, as produced by the grayscale stage) and expands it back to a 24-bit RGB pixel `{R,G,B}` using a selectable false-colour map.
- Sits between the luminance processing chain and the 24-bit display/frame-buffer path.
- Two-stage pipeline with valid/ready handshake on both sides, full back-pressure support, end-of-line flag pass-through and an output pixel counter.

Parameters:
- CNT_W, 16, width of the output pixel counter (wraps).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_y  in  8  luminance sample Y.
- in_last  in  1  end-of-line marker travelling with the sample.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- mode  in  2  map select, sampled with each accepted pixel: 0 gray, 1 jet, 2 heat, 3 threshold.
- thr  in  8  threshold for mode 3, sampled with each accepted pixel.
- pix_out  out  24  `{R[23:16], G[15:8], B[7:0]}`.
- out_last  out  1  in_last of the same pixel.
- out_valid  out  1  pix_out valid.
- out_ready  in  1  downstream accepts.
- pix_count  out  CNT_W  number of output handshakes since reset, modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, active-high, dominates everything): s1_valid=0, out_valid=0, pix_out=0, out_last=0, pix_count=0. A pixel held in either stage is discarded, not delivered.
- Handshake: a transfer occurs on the input when in_valid&in_ready, and on the output when out_valid&out_ready.
- Payload stability: once out_valid=1, pix_out/out_last hold until accepted. in_valid may be asserted without waiting for in_ready.
- Advance rules:
  - adv2 = !out_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1, combinational; no combinational path from in_valid to in_ready.
- Stage 1 (on adv1): capture in_y, in_last, mode, thr; s1_valid <= in_valid.
- Stage 2 (on adv2): compute the map from stage-1 registers; pix_out/out_last registered; out_valid <= s1_valid.
- Latency: 2 cycles from input handshake to out_valid when unstalled. Throughput 1 pixel/cycle with out_ready held high.
- Simultaneous input and output handshake in the same cycle is legal, and no pixel is lost or duplicated.
- Map arithmetic: unsigned, 8-bit results, no rounding. Let d = Y[5:0]<<2, a 0..252 value.
  - mode 0: R=G=B=Y.
  - mode 1 (jet):
    - Y<64: R=0, G=d, B=255.
    - 64..127: R=0, G=255, B=255-d.
    - 128..191: R=d, G=255, B=0.
    - >=192: R=255, G=255-d, B=0.
  - mode 2 (heat):
    - Y<128: R=Y<<1, G=0, B=0.
    - Y>=128: R=255, G=(Y-128)<<1, B=0.
  - mode 3: Y>=thr gives 0xFFFFFF, else 0x000000. With thr=0 every pixel is white.
- pix_count increments by 1 on every output handshake and wraps from 2^CNT_W-1 to 0.
- mode/thr changes take effect only for pixels accepted after the change; pixels already in flight keep their captured mode.

Decomposition:
- Package pix_pkg:
  - typedef rgb_t as a packed struct {R,G,B} of 8 bits each.
  - enum cmap_e {CMAP_GRAY, CMAP_JET, CMAP_HEAT, CMAP_THRESH}.
  - Constants WHITE=24'hFFFFFF and BLACK=24'h000000.
- One combinational sub-module, colormap_lut (inputs y, mode, thr; output rgb_t), instantiated between stage 1 and stage 2. The top level holds only handshake, registers and counter.

Test Plan:
- Reset then stream Y=0,63,64,127,128,191,192,255 in mode 1, out_ready=1:
  - outputs in order 0x0000FF, 0x00FCFF, 0x00FFFF, 0x00FF03, 0x00FF00, 0xFCFF00, 0xFFFF00, 0xFF0300.
  - First out_valid exactly 2 cycles after the first input handshake.
  - pix_count=8.
- Mode 2, Y=0,127,128,255 → 0x000000, 0xFE0000, 0xFF0000, 0xFFFE00. Mode 0, Y=0x5A → 0x5A5A5A.
- Mode 3, thr=100, Y=99,100,101 → 0x000000, 0xFFFFFF, 0xFFFFFF. thr=0, Y=0 → 0xFFFFFF.
- Back-pressure: continuous in_valid with random out_ready (~50%):
  - output sequence equals input order with no loss or duplication.
  - pix_out stable while out_valid&!out_ready.
  - in_ready drops only when both stages are full.
- Mode switched 0→1 between consecutive accepted pixels Y=128,128 → 0x808080 then 0x00FF00. in_last set on the 3rd pixel → out_last set only on the 3rd output.
- Assert reset with both stages full and out_ready=0 → next cycle out_valid=0, pix_out=0, pix_count=0, in_ready=1, and no stale pixel appears afterwards.
- Counter wrap: with CNT_W=4, send 17 pixels → pix_count=1.
